// File: rtl/num_formatter.sv
// num_formatter: turns a packed numeric word (sign, binary mantissa, count of
// fractional digits) back into a stream of button-code tokens ('-', digits, '.')
// for the display buffer. The mantissa is converted to BCD one bit per cycle by
// double-dabble, then the tokens are streamed over a valid/ready handshake.
module num_formatter #(
   parameter int NEWWIDTH   = 42,
   parameter int WIDTH      = 8,
   parameter int MANT_BITS  = 33,
   parameter int DIGITS     = 10,
   parameter int DOT_CODE   = 16,
   parameter int MINUS_CODE = 11
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [NEWWIDTH-1:0] value,
   output logic                busy,
   output logic [WIDTH-1:0]    tokOut,
   output logic                tokValid,
   input  logic                tokReady,
   output logic                tokLast,
   output logic                done,
   output logic                err
);

   localparam int BCD_BITS = 4 * DIGITS;
   localparam logic [WIDTH-1:0] DOT_TOK   = WIDTH'(DOT_CODE);
   localparam logic [WIDTH-1:0] MINUS_TOK = WIDTH'(MINUS_CODE);
   localparam logic [5:0]       LAST_SHIFT = 6'(MANT_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONVERT,
      S_EMIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t                 state_q, state_d;
   logic [MANT_BITS-1:0]   mant_q, mant_d;
   logic [BCD_BITS-1:0]    bcd_q, bcd_d;
   logic [5:0]             cnt_q, cnt_d;
   logic                   sign_q, sign_d;
   logic [3:0]             frac_q, frac_d;
   logic                   neg_q, neg_d;
   logic [3:0]             int_q, int_d;
   logic [3:0]             idx_q, idx_d;
   logic [WIDTH-1:0]       tok_out_q, tok_out_d;
   logic                   tok_valid_q, tok_valid_d;
   logic                   tok_last_q, tok_last_d;

   logic [BCD_BITS-1:0]    bcd_shift;
   logic [MANT_BITS-1:0]   mant_shift;
   logic [3:0]             nsig_calc;
   logic [3:0]             int_calc;
   logic                   neg_calc;

   // Number of tokens in the stream for a given layout.
   function automatic logic [3:0] tok_count(input logic neg, input logic [3:0] intd,
                                            input logic [3:0] frac);
      logic [3:0] n;
      n = intd + {3'b000, neg};
      if (frac != 4'd0) begin
         n = n + frac + 4'd1;
      end
      return n;
   endfunction

   // Token at stream position idx: optional minus, integer digits MS first,
   // then dot and fractional digits. Digit position 0 is the least significant.
   function automatic logic [WIDTH-1:0] tok_at(input logic [3:0] idx, input logic neg,
                                               input logic [3:0] intd, input logic [3:0] frac,
                                               input logic [BCD_BITS-1:0] bcd);
      logic [3:0]       k;
      logic [3:0]       pos;
      logic [3:0]       dig;
      logic [WIDTH-1:0] result;
      k      = idx;
      pos    = 4'd0;
      dig    = 4'd0;
      result = '0;
      if (neg && (k == 4'd0)) begin
         result = MINUS_TOK;
      end else begin
         if (neg) begin
            k = k - 4'd1;
         end
         if (k == intd) begin
            result = DOT_TOK;
         end else begin
            if (k < intd) begin
               pos = frac + (intd - 4'd1 - k);
            end else begin
               pos = frac - (k - intd);
            end
            for (int i = 0; i < DIGITS; i++) begin
               if (pos == 4'(i)) begin
                  dig = bcd[i*4 +: 4];
               end
            end
            result = {{(WIDTH-4){1'b0}}, dig};
         end
      end
      return result;
   endfunction

   // One double-dabble step: add 3 to every digit >= 5, then shift the next
   // mantissa bit in at the bottom.
   always_comb begin
      logic [BCD_BITS-1:0] adj;
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
         end
      end
      bcd_shift  = {adj[BCD_BITS-2:0], mant_q[MANT_BITS-1]};
      mant_shift = {mant_q[MANT_BITS-2:0], 1'b0};
   end

   // Layout of the finished BCD value: significant digits, integer digits, sign.
   always_comb begin
      nsig_calc = 4'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] != 4'd0) begin
            nsig_calc = 4'(i + 1);
         end
      end
      int_calc = (nsig_calc > frac_q) ? (nsig_calc - frac_q) : 4'd1;
      neg_calc = sign_q && (bcd_q != '0);
   end

   // Next-state logic: latch, convert for MANT_BITS cycles, then stream tokens.
   always_comb begin
      state_d     = state_q;
      mant_d      = mant_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      frac_d      = frac_q;
      neg_d       = neg_q;
      int_d       = int_q;
      idx_d       = idx_q;
      tok_out_d   = tok_out_q;
      tok_valid_d = tok_valid_q;
      tok_last_d  = tok_last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mant_d = value[NEWWIDTH-2:8];
               sign_d = value[NEWWIDTH-1];
               frac_d = value[3:0];
               bcd_d  = '0;
               cnt_d  = 6'd0;
               if (value[7:0] > 8'(DIGITS - 1)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_CONVERT;
               end
            end
         end
         S_CONVERT: begin
            if (cnt_q == LAST_SHIFT) begin
               neg_d       = neg_calc;
               int_d       = int_calc;
               idx_d       = 4'd0;
               tok_out_d   = tok_at(4'd0, neg_calc, int_calc, frac_q, bcd_q);
               tok_last_d  = (tok_count(neg_calc, int_calc, frac_q) == 4'd1);
               tok_valid_d = 1'b1;
               state_d     = S_EMIT;
            end else begin
               bcd_d  = bcd_shift;
               mant_d = mant_shift;
               cnt_d  = cnt_q + 6'd1;
            end
         end
         S_EMIT: begin
            if (tok_valid_q && tokReady) begin
               if (tok_last_q) begin
                  tok_valid_d = 1'b0;
                  tok_last_d  = 1'b0;
                  state_d     = S_DONE;
               end else begin
                  idx_d      = idx_q + 4'd1;
                  tok_out_d  = tok_at(idx_q + 4'd1, neg_q, int_q, frac_q, bcd_q);
                  tok_last_d = ((idx_q + 4'd2) == tok_count(neg_q, int_q, frac_q));
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mant_q      <= '0;
         bcd_q       <= '0;
         cnt_q       <= 6'd0;
         sign_q      <= 1'b0;
         frac_q      <= 4'd0;
         neg_q       <= 1'b0;
         int_q       <= 4'd0;
         idx_q       <= 4'd0;
         tok_out_q   <= '0;
         tok_valid_q <= 1'b0;
         tok_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mant_q      <= mant_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         frac_q      <= frac_d;
         neg_q       <= neg_d;
         int_q       <= int_d;
         idx_q       <= idx_d;
         tok_out_q   <= tok_out_d;
         tok_valid_q <= tok_valid_d;
         tok_last_q  <= tok_last_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign err      = (state_q == S_ERR);
   assign tokOut   = tok_out_q;
   assign tokValid = tok_valid_q;
   assign tokLast  = tok_last_q;

endmodule

// File: doc/num_formatter.md
Name: num_formatter

Overview:
Inverse of the number builder. Takes one 42-bit packed numeric word (sign, binary mantissa, fractional-digit count) and serialises it back into 8-bit button-code tokens (digits, '.', '-') for the display/token buffer. Sits between the evaluator result and the display memory. Streams tokens out over a valid/ready handshake.

Parameters:
NEWWIDTH, 42, packed numeric word width
WIDTH, 8, token width
MANT_BITS, 33, unsigned mantissa width, value[40:8]
DIGITS, 10, BCD digits produced; covers 2^33-1
DOT_CODE, 16, token code for '.'
MINUS_CODE, 11, token code for '-'

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets
start  in  1  request conversion of value; sampled only in IDLE
value  in  NEWWIDTH  [41]=sign, [40:8]=unsigned mantissa, [7:0]=frac digit count
busy  out  1  high in every state except IDLE
tokOut  out  WIDTH  current token code
tokValid  out  1  tokOut valid
tokReady  in  1  consumer accepts token when tokValid&&tokReady at a clock edge
tokLast  out  1  high with the final token of the number
done  out  1  one-cycle pulse after the last token is accepted
err  out  1  one-cycle pulse when frac count > DIGITS-1; no tokens emitted

Behaviour:
- Reset (reset==0 at clock edge, any state, including mid-CONVERT/EMIT): state=IDLE; busy, tokValid, tokLast, done, err = 0; tokOut = 0; BCD/shift registers cleared. No partial stream resumes.
- States: IDLE -> CONVERT -> EMIT -> DONE -> IDLE; IDLE -> ERR -> IDLE.
- IDLE: on start=1, latch value. If value[7:0] > 9: go to ERR (err=1 for exactly that one cycle), then IDLE. Otherwise go to CONVERT.
- CONVERT: double-dabble of the 33-bit mantissa into 10 BCD digits, one shift per cycle, exactly MANT_BITS cycles. Then compute: nsig = index of the most-significant nonzero digit + 1 (minimum 1); intDigits = max(1, nsig - frac); neg = sign && mantissa != 0.
- First tokValid is high in the cycle after the 33rd shift, 34 cycles after the start edge.
- EMIT order:
  - MINUS_CODE, if neg.
  - intDigits integer digits, most-significant first; leading zeros are emitted only when needed, e.g. the single "0" in "0.05".
  - If frac > 0: DOT_CODE, then frac fractional digits. Trailing zeros are kept.
- Handshake: tokOut, tokValid and tokLast are registered and hold stable while tokValid && !tokReady. The next token is presented the cycle after acceptance. Zero bubbles under continuous tokReady: one token per cycle.
- tokLast is high only with the final token.
- DONE: one cycle; done=1, busy=1. Next state is IDLE.
- start while busy is ignored; value changes after latch have no effect.
- Mantissa 0: emits "0", or "0." followed by frac zeros. Negative zero has no minus.
- Token count = neg + intDigits + (frac>0 ? 1+frac : 0). Maximum is 1+10+1 = 12 (the frac<=9 cap).
- tokReady asserted while tokValid=0 has no effect.

Test Plan:
- value={0, 832341, 4}, start, tokReady=1 -> tokens 8,3,16,2,3,4,1; tokLast only on the final 1; first tokValid 34 cycles after start; done pulses 1 cycle after last accept.
- value={1, 5, 2} -> tokens 11,0,16,0,5 ("-0.05"); busy falls after done.
- value={1, 0, 0} -> single token 0 with tokLast=1, no MINUS_CODE. value={0, 0, 3} -> 0,16,0,0,0.
- value={0, 8589934591, 0} -> 8,5,8,9,9,3,4,5,9,1; 10 tokens; no dot.
- Backpressure: {0,1234,1} with tokReady low for 3 cycles at token 3 -> tokOut stays 3 with tokValid=1 for those 3 cycles; consumer sees exactly 1,2,3,16,4. A start pulse during EMIT is ignored.
- Error and reset:
  - value={0,7,12} -> err high exactly 1 cycle; tokValid never asserts; busy returns to 0.
  - reset=0 for one edge mid-EMIT -> next cycle tokValid=0, busy=0. A fresh start then produces a full, correct stream.
